// File: rtl/pipe_arbiter_if.sv
// Bus bundle for pipe_arbiter: requester handshake, flush, and pipeline outputs.
// The master side drives requests; the slave side is the arbiter itself.
interface pipe_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int NUM_STAGES = 3,
    parameter int DATA_WIDTH = 16
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(NUM_STAGES + 1);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          flush;
    logic                          out_valid;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [ID_W-1:0]               out_id;
    logic [CNT_W-1:0]              inflight;
    logic                          busy;

    modport master (
        output req_valid, req_data, flush,
        input  req_ready, out_valid, out_data, out_id, inflight, busy
    );

    modport slave (
        input  req_valid, req_data, flush,
        output req_ready, out_valid, out_data, out_id, inflight, busy
    );
endinterface

// File: rtl/pipe_arbiter.sv
// Round-robin arbiter feeding a fixed-depth, non-stalling pipeline.
// One requester is accepted per cycle; its payload and index emerge
// NUM_STAGES cycles later. A flush kills everything in flight.
module pipe_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int NUM_STAGES = 3,
    parameter int DATA_WIDTH = 16
) (
    input  logic         clk,
    input  logic         rstn,
    pipe_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(NUM_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [ID_W-1:0]  ID_ONE  = ID_W'(1);

    // Round-robin pointer: index of the requester with highest priority.
    logic [ID_W-1:0]       ptr;
    logic [ID_W-1:0]       ptr_next;

    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       grant_idx;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  stage_valid [NUM_STAGES];
    logic [ID_W-1:0]       stage_id    [NUM_STAGES];
    logic [DATA_WIDTH-1:0] stage_data  [NUM_STAGES];

    logic [CNT_W-1:0]      count;
    logic                  retire;

    // Pick the first valid requester scanning from ptr upward with wrap.
    // Grants are also suppressed while rstn is low so nothing is offered
    // to a requester while the pipeline is being cleared.
    always_comb begin : arbitrate
        int   idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        if (rstn && !bus.flush) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(ptr) + k) % NUM_REQ;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!found && (i == idx) && bus.req_valid[i]) begin
                        found     = 1'b1;
                        grant[i]  = 1'b1;
                        grant_idx = ID_W'(i);
                    end
                end
            end
        end
    end

    // Select the granted requester's payload for capture into stage 0.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign accept = |grant;

    // Pointer successor after a grant, wrapping at NUM_REQ (not a power of two in general).
    always_comb begin
        if (int'(grant_idx) == NUM_REQ - 1) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_idx + ID_ONE;
        end
    end

    // Advance the priority pointer past the winner; hold when nothing is granted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= ptr_next;
        end
    end

    // Shift the pipeline every cycle; flush wipes all valid bits.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                stage_valid[s] <= 1'b0;
                stage_id[s]    <= '0;
                stage_data[s]  <= '0;
            end
        end else begin
            stage_valid[0] <= accept;
            stage_id[0]    <= grant_idx;
            stage_data[0]  <= sel_data;
            for (int s = 1; s < NUM_STAGES; s++) begin
                stage_valid[s] <= stage_valid[s-1];
                stage_id[s]    <= stage_id[s-1];
                stage_data[s]  <= stage_data[s-1];
            end
            if (bus.flush) begin
                for (int s = 0; s < NUM_STAGES; s++) begin
                    stage_valid[s] <= 1'b0;
                end
            end
        end
    end

    assign retire = stage_valid[NUM_STAGES-1];

    // Track the number of valid stages; accept and retire together cancel out.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (bus.flush) begin
            count <= '0;
        end else if (accept && !retire) begin
            count <= count + CNT_ONE;
        end else if (!accept && retire) begin
            count <= count - CNT_ONE;
        end
    end

    assign bus.req_ready = grant;
    assign bus.out_valid = retire;
    assign bus.out_data  = retire ? stage_data[NUM_STAGES-1] : '0;
    assign bus.out_id    = retire ? stage_id[NUM_STAGES-1]   : '0;
    assign bus.inflight  = count;
    assign bus.busy      = (count != '0);
endmodule

// File: tb/tb_pipe_arbiter.sv
// Directed bench for pipe_arbiter with NUM_REQ=2, NUM_STAGES=3, DATA_WIDTH=16.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
module tb_pipe_arbiter;
    logic clk;
    logic rstn;
    int   n_checks;
    int   n_pass;

    pipe_arbiter_if #(.NUM_REQ(2), .NUM_STAGES(3), .DATA_WIDTH(16)) bus ();

    pipe_arbiter #(.NUM_REQ(2), .NUM_STAGES(3), .DATA_WIDTH(16)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the edge, then settle before checks.
    task automatic apply_stimulus(input logic [1:0] rv, input logic [15:0] d0,
                                  input logic [15:0] d1, input logic fl);
        @(posedge clk);
        #1;
        bus.req_valid = rv;
        bus.req_data  = {d1, d0};
        bus.flush     = fl;
        #2;
    endtask

    // Single comparison point.
    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Compare the three pipeline output fields at once.
    task automatic check_pipe(input string tag, input logic ov, input logic [15:0] od, input logic oid);
        check_output({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
        check_output({tag, ".out_data"},  32'(bus.out_data),  32'(od));
        check_output({tag, ".out_id"},    32'(bus.out_id),    32'(oid));
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rstn          = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_data  = {16'h2222, 16'h1111};
        bus.flush     = 1'b0;

        // Reset state with requests pending
        #12;
        check_output("rst.req_ready", 32'(bus.req_ready), 32'h0);
        check_pipe("rst", 1'b0, 16'h0000, 1'b0);
        check_output("rst.inflight", 32'(bus.inflight), 32'h0);
        check_output("rst.busy", 32'(bus.busy), 32'h0);

        @(posedge clk);
        #2;
        bus.req_valid = 2'b00;
        rstn = 1'b1;
        $display("[TB] reset released");

        // Single request, then idle until it retires
        apply_stimulus(2'b01, 16'hA5A5, 16'h0000, 1'b0);
        check_output("single.c0.req_ready", 32'(bus.req_ready), 32'h1);
        check_output("single.c0.inflight", 32'(bus.inflight), 32'h0);
        apply_stimulus(2'b00, 16'h0000, 16'h0000, 1'b0);
        check_output("single.c1.inflight", 32'(bus.inflight), 32'h1);
        check_output("single.c1.busy", 32'(bus.busy), 32'h1);
        check_output("single.c1.req_ready", 32'(bus.req_ready), 32'h0);
        check_pipe("single.c1", 1'b0, 16'h0000, 1'b0);
        apply_stimulus(2'b00, 16'h0000, 16'h0000, 1'b0);
        check_output("single.c2.inflight", 32'(bus.inflight), 32'h1);
        check_pipe("single.c2", 1'b0, 16'h0000, 1'b0);
        apply_stimulus(2'b00, 16'h0000, 16'h0000, 1'b0);
        check_output("single.c3.inflight", 32'(bus.inflight), 32'h1);
        check_pipe("single.c3", 1'b1, 16'hA5A5, 1'b0);
        apply_stimulus(2'b00, 16'h0000, 16'h0000, 1'b0);
        check_output("single.c4.inflight", 32'(bus.inflight), 32'h0);
        check_output("single.c4.busy", 32'(bus.busy), 32'h0);
        check_pipe("single.c4", 1'b0, 16'h0000, 1'b0);

        // Pointer moved to 1 after granting 0 and held through idle
        apply_stimulus(2'b11, 16'h0BAD, 16'hBEEF, 1'b0);
        check_output("hold.c5.req_ready", 32'(bus.req_ready), 32'h2);
        check_output("hold.c5.inflight", 32'(bus.inflight), 32'h0);

        // Contention: alternating grants, full pipeline
        apply_stimulus(2'b11, 16'h1111, 16'h2222, 1'b0);
        check_output("cont.c6.req_ready", 32'(bus.req_ready), 32'h1);
        check_output("cont.c6.inflight", 32'(bus.inflight), 32'h1);
        apply_stimulus(2'b11, 16'h1111, 16'h2222, 1'b0);
        check_output("cont.c7.req_ready", 32'(bus.req_ready), 32'h2);
        check_output("cont.c7.inflight", 32'(bus.inflight), 32'h2);
        apply_stimulus(2'b11, 16'h1111, 16'h2222, 1'b0);
        check_output("cont.c8.req_ready", 32'(bus.req_ready), 32'h1);
        check_output("cont.c8.inflight", 32'(bus.inflight), 32'h3);
        check_pipe("cont.c8", 1'b1, 16'hBEEF, 1'b1);
        apply_stimulus(2'b11, 16'h1111, 16'h2222, 1'b0);
        check_output("cont.c9.req_ready", 32'(bus.req_ready), 32'h2);
        check_output("cont.c9.inflight", 32'(bus.inflight), 32'h3);
        check_pipe("cont.c9", 1'b1, 16'h1111, 1'b0);
        // Payload changes after acceptance must not reach in-flight entries
        apply_stimulus(2'b00, 16'hFFFF, 16'hFFFF, 1'b0);
        check_output("cont.c10.req_ready", 32'(bus.req_ready), 32'h0);
        check_output("cont.c10.inflight", 32'(bus.inflight), 32'h3);
        check_pipe("cont.c10", 1'b1, 16'h2222, 1'b1);
        apply_stimulus(2'b00, 16'hFFFF, 16'hFFFF, 1'b0);
        check_output("cont.c11.inflight", 32'(bus.inflight), 32'h2);
        check_pipe("cont.c11", 1'b1, 16'h1111, 1'b0);
        apply_stimulus(2'b00, 16'hFFFF, 16'hFFFF, 1'b0);
        check_output("cont.c12.inflight", 32'(bus.inflight), 32'h1);
        check_pipe("cont.c12", 1'b1, 16'h2222, 1'b1);

        // Flush: one entry retires in the flush cycle, two younger ones are killed
        apply_stimulus(2'b10, 16'h0000, 16'h7777, 1'b0);
        check_output("flush.c13.req_ready", 32'(bus.req_ready), 32'h2);
        check_output("flush.c13.busy", 32'(bus.busy), 32'h0);
        check_pipe("flush.c13", 1'b0, 16'h0000, 1'b0);
        apply_stimulus(2'b01, 16'h0001, 16'h0000, 1'b0);
        check_output("flush.c14.req_ready", 32'(bus.req_ready), 32'h1);
        apply_stimulus(2'b01, 16'h0002, 16'h0000, 1'b0);
        check_output("flush.c15.req_ready", 32'(bus.req_ready), 32'h1);
        apply_stimulus(2'b11, 16'h0003, 16'h0004, 1'b1);
        check_output("flush.c16.req_ready", 32'(bus.req_ready), 32'h0);
        check_output("flush.c16.inflight", 32'(bus.inflight), 32'h3);
        check_pipe("flush.c16", 1'b1, 16'h7777, 1'b1);
        apply_stimulus(2'b00, 16'h0000, 16'h0000, 1'b0);
        check_output("flush.c17.inflight", 32'(bus.inflight), 32'h0);
        check_output("flush.c17.busy", 32'(bus.busy), 32'h0);
        check_pipe("flush.c17", 1'b0, 16'h0000, 1'b0);
        apply_stimulus(2'b00, 16'h0000, 16'h0000, 1'b0);
        check_pipe("flush.c18", 1'b0, 16'h0000, 1'b0);
        apply_stimulus(2'b00, 16'h0000, 16'h0000, 1'b0);
        check_pipe("flush.c19", 1'b0, 16'h0000, 1'b0);
        // Pointer was 1 before the flush and must still be 1
        apply_stimulus(2'b11, 16'h3030, 16'h3333, 1'b0);
        check_output("flush.c20.req_ready", 32'(bus.req_ready), 32'h2);

        // Async reset with three entries in flight
        apply_stimulus(2'b11, 16'h4444, 16'h4545, 1'b0);
        check_output("arst.c21.req_ready", 32'(bus.req_ready), 32'h1);
        apply_stimulus(2'b11, 16'h5454, 16'h5555, 1'b0);
        check_output("arst.c22.req_ready", 32'(bus.req_ready), 32'h2);
        apply_stimulus(2'b00, 16'h0000, 16'h0000, 1'b0);
        check_output("arst.c23.inflight", 32'(bus.inflight), 32'h3);
        check_pipe("arst.c23", 1'b1, 16'h3333, 1'b1);
        #1;
        rstn = 1'b0;
        bus.req_valid = 2'b11;
        #1;
        check_pipe("arst.during", 1'b0, 16'h0000, 1'b0);
        check_output("arst.during.inflight", 32'(bus.inflight), 32'h0);
        check_output("arst.during.busy", 32'(bus.busy), 32'h0);
        check_output("arst.during.req_ready", 32'(bus.req_ready), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2;
        bus.req_valid = 2'b00;
        rstn = 1'b1;

        // First grant after release follows pointer 0; no stale outputs
        apply_stimulus(2'b11, 16'h6666, 16'h6767, 1'b0);
        check_output("post.r0.req_ready", 32'(bus.req_ready), 32'h1);
        check_pipe("post.r0", 1'b0, 16'h0000, 1'b0);
        apply_stimulus(2'b00, 16'h0000, 16'h0000, 1'b0);
        check_output("post.r1.inflight", 32'(bus.inflight), 32'h1);
        check_pipe("post.r1", 1'b0, 16'h0000, 1'b0);
        apply_stimulus(2'b00, 16'h0000, 16'h0000, 1'b0);
        check_pipe("post.r2", 1'b0, 16'h0000, 1'b0);
        apply_stimulus(2'b00, 16'h0000, 16'h0000, 1'b0);
        check_pipe("post.r3", 1'b1, 16'h6666, 1'b0);
        apply_stimulus(2'b00, 16'h0000, 16'h0000, 1'b0);
        check_pipe("post.r4", 1'b0, 16'h0000, 1'b0);
        check_output("post.r4.inflight", 32'(bus.inflight), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
